// File: rtl/updown_counter_prog.sv
// Programmable-modulus up/down counter with run-time bound, variable step,
// parallel load, synchronous clear and wrap / saturate / one-shot end modes.
module updown_counter_prog #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              en,
   input  logic              up_down,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  max_val,
   input  logic [1:0]        mode,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              done,
   output logic              at_zero,
   output logic              at_max
);

   typedef enum logic [1:0] {
      MODE_WRAP     = 2'd0,
      MODE_SAT      = 2'd1,
      MODE_ONESHOT  = 2'd2,
      MODE_WRAP_ALT = 2'd3
   } mode_e;

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_done;

   logic [WIDTH-1:0] w_count_nxt;
   logic             w_tc_nxt;
   logic             w_done_nxt;

   mode_e            w_mode;
   logic [WIDTH:0]   w_cnt_x;
   logic [WIDTH:0]   w_max_x;
   logic [WIDTH:0]   w_step_x;
   logic [WIDTH:0]   w_s;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_sum_wrap;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_diff_wrap;
   logic [WIDTH-1:0] w_load_clamped;
   logic             w_frozen;
   logic             w_saturating;

   // All arithmetic is carried at WIDTH+1 bits so count + s and
   // count + max_val + 1 never overflow before comparison.
   assign w_mode         = mode_e'(mode);
   assign w_cnt_x        = {1'b0, r_count};
   assign w_max_x        = {1'b0, max_val};
   assign w_step_x       = (WIDTH+1)'(step);
   assign w_s            = (w_step_x > w_max_x) ? w_max_x : w_step_x;
   assign w_sum          = w_cnt_x + w_s;
   assign w_sum_wrap     = w_sum - (w_max_x + ONE);
   assign w_diff         = w_cnt_x - w_s;
   assign w_diff_wrap    = w_cnt_x + w_max_x + ONE - w_s;
   assign w_load_clamped = (load_val > max_val) ? max_val : load_val;
   assign w_saturating   = (w_mode == MODE_SAT) || (w_mode == MODE_ONESHOT);
   assign w_frozen       = (w_mode == MODE_ONESHOT) && r_done;

   // Next-state selection: clr > load > enabled step.
   always_comb begin
      w_count_nxt = r_count;
      w_tc_nxt    = 1'b0;
      w_done_nxt  = r_done;
      if (clr) begin
         w_count_nxt = '0;
         w_done_nxt  = 1'b0;
      end else if (load) begin
         w_count_nxt = w_load_clamped;
         w_done_nxt  = 1'b0;
      end else if (en && !w_frozen && (w_s != '0)) begin
         if (w_cnt_x > w_max_x) begin
            // Bound was lowered beneath the current count: snap to it quietly.
            w_count_nxt = max_val;
         end else if (w_saturating) begin
            if (up_down) begin
               if (w_sum >= w_max_x) begin
                  w_count_nxt = max_val;
                  w_tc_nxt    = (r_count != max_val);
               end else begin
                  w_count_nxt = w_sum[WIDTH-1:0];
               end
            end else begin
               if (w_s >= w_cnt_x) begin
                  w_count_nxt = '0;
                  w_tc_nxt    = (r_count != '0);
               end else begin
                  w_count_nxt = w_diff[WIDTH-1:0];
               end
            end
            if ((w_mode == MODE_ONESHOT) && w_tc_nxt)
               w_done_nxt = 1'b1;
         end else begin
            if (up_down) begin
               if (w_sum > w_max_x) begin
                  w_count_nxt = w_sum_wrap[WIDTH-1:0];
                  w_tc_nxt    = 1'b1;
               end else begin
                  w_count_nxt = w_sum[WIDTH-1:0];
               end
            end else begin
               if (w_s > w_cnt_x) begin
                  w_count_nxt = w_diff_wrap[WIDTH-1:0];
                  w_tc_nxt    = 1'b1;
               end else begin
                  w_count_nxt = w_diff[WIDTH-1:0];
               end
            end
         end
      end
   end

   // Count, terminal-count pulse and sticky done flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_tc    <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_tc    <= w_tc_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign count   = r_count;
   assign tc      = r_tc;
   assign done    = r_done;
   assign at_zero = (r_count == '0);
   assign at_max  = (r_count == max_val);

endmodule

// File: tb/tb_updown_counter_prog.sv
// Scoreboard bench for updown_counter_prog (WIDTH = 4, STEP_W = 4).
module tb_updown_counter_prog;

   localparam int unsigned W  = 4;
   localparam int unsigned SW = 4;

   logic          clk;
   logic          rst;
   logic          clr;
   logic          load;
   logic [W-1:0]  load_val;
   logic          en;
   logic          up_down;
   logic [SW-1:0] step;
   logic [W-1:0]  max_val;
   logic [1:0]    mode;
   logic [W-1:0]  count;
   logic          tc;
   logic          done;
   logic          at_zero;
   logic          at_max;

   typedef struct {
      int          tag;
      logic [W-1:0] cnt;
      logic        tc;
      logic        done;
      logic [W-1:0] maxv;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   tag_ctr = 0;

   updown_counter_prog #(.WIDTH(W), .STEP_W(SW)) dut (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up_down(up_down), .step(step), .max_val(max_val),
      .mode(mode), .count(count), .tc(tc), .done(done),
      .at_zero(at_zero), .at_max(at_max)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string name, input int tag, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s (vector %0d): got %0d, expected %0d", name, tag, act, expv);
      end
   endtask

   // One clocked vector: drive at the falling edge, push the hand-computed result.
   task automatic cyc(input logic c, input logic l, input int lv, input logic e,
                      input logic ud, input int st, input int mx, input int md,
                      input int ecnt, input logic etc, input logic edone);
      exp_t x;
      @(negedge clk);
      clr = c; load = l; load_val = W'(lv); en = e; up_down = ud;
      step = SW'(st); max_val = W'(mx); mode = 2'(md);
      tag_ctr++;
      x.tag = tag_ctr; x.cnt = W'(ecnt); x.tc = etc; x.done = edone; x.maxv = W'(mx);
      exp_q.push_back(x);
   endtask

   // Monitor: one registered result appears just after each rising edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            compare("count",   x.tag, int'(count),   int'(x.cnt));
            compare("tc",      x.tag, int'(tc),      int'(x.tc));
            compare("done",    x.tag, int'(done),    int'(x.done));
            compare("at_zero", x.tag, int'(at_zero), int'(x.cnt == '0));
            compare("at_max",  x.tag, int'(at_max),  int'(x.cnt == x.maxv));
         end
      end
   end

   initial begin
      rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0;
      up_down = 1'b1; step = '0; max_val = 4'd15; mode = 2'd0;
      #12;
      compare("reset count", 0, int'(count), 0);
      compare("reset tc",    0, int'(tc),    0);
      compare("reset done",  0, int'(done),  0);
      @(negedge clk);
      rst = 1'b0;

      // Mid-cycle asynchronous reset aborts counting, then resumes from 0.
      cyc(0,0,0, 1,1,3,15,0,  3,0,0);
      cyc(0,0,0, 1,1,3,15,0,  6,0,0);
      @(posedge clk);
      #3;
      rst = 1'b1; en = 1'b0;
      #1;
      compare("async rst count", -1, int'(count), 0);
      compare("async rst tc",    -1, int'(tc),    0);
      compare("async rst done",  -1, int'(done),  0);
      @(negedge clk);
      rst = 1'b0;
      cyc(0,0,0, 1,1,3,15,0,  3,0,0);

      // Wrap up, max 9, step 3.
      cyc(1,0,0, 0,1,3,9,0,   0,0,0);
      cyc(0,0,0, 1,1,3,9,0,   3,0,0);
      cyc(0,0,0, 1,1,3,9,0,   6,0,0);
      cyc(0,0,0, 1,1,3,9,0,   9,0,0);
      cyc(0,0,0, 1,1,3,9,0,   2,1,0);

      // Wrap down, max 9; step 15 clamps to 9.
      cyc(0,1,5, 0,0,4,9,0,   5,0,0);
      cyc(0,0,0, 1,0,4,9,0,   1,0,0);
      cyc(0,0,0, 1,0,4,9,0,   7,1,0);
      cyc(0,0,0, 1,0,4,9,0,   3,0,0);
      cyc(0,0,0, 1,0,15,9,0,  4,1,0);

      // Saturate, max 15.
      cyc(0,1,12, 0,1,5,15,1, 12,0,0);
      cyc(0,0,0,  1,1,5,15,1, 15,1,0);
      cyc(0,0,0,  1,1,5,15,1, 15,0,0);
      cyc(0,0,0,  1,0,15,15,1, 0,1,0);
      cyc(0,0,0,  1,0,15,15,1, 0,0,0);

      // One-shot down from 7, step 2; done freezes the counter.
      cyc(0,1,7, 0,0,2,15,2,  7,0,0);
      cyc(0,0,0, 1,0,2,15,2,  5,0,0);
      cyc(0,0,0, 1,0,2,15,2,  3,0,0);
      cyc(0,0,0, 1,0,2,15,2,  1,0,0);
      cyc(0,0,0, 1,0,2,15,2,  0,1,1);
      cyc(0,0,0, 1,0,2,15,2,  0,0,1);
      cyc(0,0,0, 1,1,2,15,2,  0,0,1);
      cyc(0,1,4, 1,1,2,15,2,  4,0,0);

      // Priority, load clamping, lowered bound, zero step.
      cyc(1,1,7, 1,1,1,15,0,  0,0,0);
      cyc(0,1,12, 0,1,1,9,0,  9,0,0);
      cyc(0,0,0, 1,1,1,5,0,   5,0,0);
      cyc(0,0,0, 1,1,0,5,0,   5,0,0);
      cyc(0,0,0, 1,1,1,5,0,   0,1,0);

      @(negedge clk);
      en = 1'b0; clr = 1'b0; load = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/updown_counter_prog.md
Name: updown_counter_prog

Overview:
Programmable-modulus up/down counter: the parametrised successor to the fixed 2^WIDTH up/down counter.
- Adds a run-time upper bound, a variable step size, parallel load and synchronous clear.
- Three end-of-range modes: wrap, saturate, one-shot.
- Used for timers, frame/line counters and address sequencers that need a non-power-of-two range.

Parameters:
WIDTH, 8, counter/bound/load width in bits (≥ 2)
STEP_W, 4, step input width in bits (1 ≤ STEP_W ≤ WIDTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
clr  input  1  synchronous clear
load  input  1  synchronous parallel load
load_val  input  WIDTH  value to load
en  input  1  count enable
up_down  input  1  1 = count up, 0 = count down
step  input  STEP_W  increment/decrement magnitude
max_val  input  WIDTH  inclusive upper bound; range is 0..max_val
mode  input  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = treated as wrap
count  output  WIDTH  registered count
tc  output  1  registered terminal-count pulse
done  output  1  registered sticky one-shot completion flag
at_zero  output  1  combinational: count == 0
at_max  output  1  combinational: count == max_val

Behaviour:
- Reset: rst = 1 asynchronously forces count = 0, tc = 0, done = 0, independent of up_down. Mid-operation reset aborts the current count immediately.
- Update priority per rising clk edge: clr > load > en.
  - clr: count = 0, done = 0, tc = 0.
  - load: count = min(load_val, max_val), done = 0, tc = 0.
  - en = 0 or (mode = one-shot and done = 1): count holds, tc = 0.
- Effective step s = min(step, max_val), zero-extended to WIDTH+1 bits. All sums use WIDTH+1 bits, so no intermediate overflow.
- s = 0 (step = 0 or max_val = 0): count holds, tc = 0.
- Out-of-range count: if count > max_val at an enabled step (max_val lowered), next count = max_val in all modes and tc = 0.
- Wrap mode:
  - Up: sum = count + s. If sum > max_val then count = sum − (max_val + 1) and tc = 1; else count = sum.
  - Down: if s > count then count = count + (max_val + 1) − s and tc = 1; else count = count − s.
- Saturate mode:
  - Up: count = min(count + s, max_val); tc = 1 only if this step moved count onto max_val from below.
  - Down: count = max(count − s, 0); tc = 1 only if this step moved count onto 0 from above.
  - Holding at the bound produces no repeated tc.
- One-shot mode:
  - Arithmetic as saturate.
  - On the step that reaches the bound (tc = 1), done is set.
  - While done = 1, en is ignored.
  - done clears only on clr, load or rst.
- tc is a single-cycle pulse registered with the same edge that updates count.
- up_down may change every cycle; direction is sampled per enabled step.
- Latency: count reflects a clr, load or step one cycle after the sampling edge. at_zero and at_max follow count combinationally.

Test Plan:
1. WIDTH = 4: count at 6, assert rst mid-cycle → count = 0, tc = 0, done = 0 before the next edge; release → counting resumes from 0.
2. Wrap up: max_val = 9, step = 3, en = 1 from 0 → 3, 6, 9, 2. tc = 1 only on the cycle count becomes 2.
3. Wrap down: max_val = 9, load 5, step = 4 → 1, 7 (tc = 1), 3. With step = 15, s is clamped to 9: from 3 → 4 (tc = 1).
4. Saturate: max_val = 15, load 12, step = 5, up → 15 (tc = 1), 15 (tc = 0). Then down, step = 15 → 0 (tc = 1), 0 (tc = 0).
5. One-shot down: load 7, step = 2 → 5, 3, 1, 0 (tc = 1, done = 1). Further en keeps count = 0 with tc = 0. Load 4 → count = 4, done = 0.
6. Priority and clamping:
   - clr = load = en = 1 same cycle → count = 0.
   - load_val = 12 with max_val = 9 → count = 9.
   - Lower max_val to 5 with count = 9, enabled step → count = 5, tc = 0.
